// File: rtl/axi_r_router_if.sv
// AXI read-data (R) channel bundle; the slave modport drives a burst,
// the master modport receives it and returns RREADY.
interface axi_r_if #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned DATA_W = 32
);
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport slave  (output rid, rdata, rresp, rlast, rvalid, input  rready);
  modport master (input  rid, rdata, rresp, rlast, rvalid, output rready);
endinterface

// File: rtl/axi_r_router.sv
// R-channel return router: round-robin burst arbitration over S0/S1/SD and
// steering to M0/M1 by the master index held in the upper RID bits.
module axi_r_router #(
  parameter int unsigned IDS_BITS  = 8,
  parameter int unsigned ID_BITS   = 4,
  parameter int unsigned DATA_BITS = 32
) (
  input  logic    ACLK,
  input  logic    ARESET,
  axi_r_if.master s0_if,
  axi_r_if.master s1_if,
  axi_r_if.master sd_if,
  axi_r_if.slave  m0_if,
  axi_r_if.slave  m1_if
);

  localparam int unsigned NS       = 3;
  localparam int unsigned NM       = 2;
  localparam int unsigned IDX_BITS = IDS_BITS - ID_BITS;

  typedef enum logic       {ST_IDLE, ST_BUSY} state_e;
  typedef enum logic [1:0] {G_S0 = 2'd0, G_S1 = 2'd1, G_SD = 2'd2} slv_e;
  typedef enum logic [1:0] {MS_M0 = 2'd0, MS_M1 = 2'd1, MS_NONE = 2'd2} msel_e;

  state_e state_q, state_d;
  slv_e   gnt_q, gnt_d;
  msel_e  msel_q, msel_d;
  slv_e   rr_q, rr_d;

  logic [IDS_BITS-1:0]  s_rid   [NS];
  logic [DATA_BITS-1:0] s_rdata [NS];
  logic [1:0]           s_rresp [NS];
  logic [NS-1:0]        s_rlast;
  logic [NS-1:0]        s_rvalid;
  logic [NS-1:0]        s_rready_c;

  logic [ID_BITS-1:0]   m_rid_c   [NM];
  logic [DATA_BITS-1:0] m_rdata_c [NM];
  logic [1:0]           m_rresp_c [NM];
  logic [NM-1:0]        m_rlast_c;
  logic [NM-1:0]        m_rvalid_c;
  logic [NM-1:0]        m_rready;

  slv_e pick, cand1, cand2;
  logic pick_vld;
  logic hs_last;
  logic mi;

  function automatic slv_e rr_next(input slv_e s);
    case (s)
      G_S0:    return G_S1;
      G_S1:    return G_SD;
      default: return G_S0;
    endcase
  endfunction

  // Master index 0/1 selects M0/M1; any other index has no owner and is drained.
  function automatic msel_e decode_msel(input logic [IDX_BITS-1:0] ix);
    if (ix == IDX_BITS'(0))      return MS_M0;
    else if (ix == IDX_BITS'(1)) return MS_M1;
    else                         return MS_NONE;
  endfunction

  assign s_rid[0]   = s0_if.rid;
  assign s_rid[1]   = s1_if.rid;
  assign s_rid[2]   = sd_if.rid;
  assign s_rdata[0] = s0_if.rdata;
  assign s_rdata[1] = s1_if.rdata;
  assign s_rdata[2] = sd_if.rdata;
  assign s_rresp[0] = s0_if.rresp;
  assign s_rresp[1] = s1_if.rresp;
  assign s_rresp[2] = sd_if.rresp;
  assign s_rlast    = {sd_if.rlast, s1_if.rlast, s0_if.rlast};
  assign s_rvalid   = {sd_if.rvalid, s1_if.rvalid, s0_if.rvalid};
  assign m_rready   = {m1_if.rready, m0_if.rready};

  assign s0_if.rready = s_rready_c[0];
  assign s1_if.rready = s_rready_c[1];
  assign sd_if.rready = s_rready_c[2];

  assign m0_if.rvalid = m_rvalid_c[0];
  assign m0_if.rid    = m_rid_c[0];
  assign m0_if.rdata  = m_rdata_c[0];
  assign m0_if.rresp  = m_rresp_c[0];
  assign m0_if.rlast  = m_rlast_c[0];
  assign m1_if.rvalid = m_rvalid_c[1];
  assign m1_if.rid    = m_rid_c[1];
  assign m1_if.rdata  = m_rdata_c[1];
  assign m1_if.rresp  = m_rresp_c[1];
  assign m1_if.rlast  = m_rlast_c[1];

  // First requester at or after the round-robin pointer.
  always_comb begin : arb_c
    cand1    = rr_next(rr_q);
    cand2    = rr_next(cand1);
    pick_vld = |s_rvalid;
    if (s_rvalid[rr_q])       pick = rr_q;
    else if (s_rvalid[cand1]) pick = cand1;
    else                      pick = cand2;
  end

  always_ff @(posedge ACLK) begin : state_reg
    if (ARESET) begin
      state_q <= ST_IDLE;
      gnt_q   <= G_S0;
      msel_q  <= MS_NONE;
      rr_q    <= G_S0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      msel_q  <= msel_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin : fsm_c
    state_d    = state_q;
    gnt_d      = gnt_q;
    msel_d     = msel_q;
    rr_d       = rr_q;
    s_rready_c = '0;
    m_rvalid_c = '0;
    m_rlast_c  = '0;
    hs_last    = 1'b0;
    mi         = 1'b0;
    for (int unsigned m = 0; m < NM; m++) begin
      m_rid_c[m]   = '0;
      m_rdata_c[m] = '0;
      m_rresp_c[m] = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_BUSY;
          gnt_d   = pick;
          msel_d  = decode_msel(s_rid[pick][IDS_BITS-1:ID_BITS]);
        end
      end
      default: begin
        if (msel_q == MS_NONE) begin
          s_rready_c[gnt_q] = 1'b1;
        end else begin
          // Combinational pass-through; payload zeroed while RVALID is low.
          mi                = (msel_q == MS_M1);
          m_rvalid_c[mi]    = s_rvalid[gnt_q];
          s_rready_c[gnt_q] = m_rready[mi];
          if (s_rvalid[gnt_q]) begin
            m_rid_c[mi]   = s_rid[gnt_q][ID_BITS-1:0];
            m_rdata_c[mi] = s_rdata[gnt_q];
            m_rresp_c[mi] = s_rresp[gnt_q];
            m_rlast_c[mi] = s_rlast[gnt_q];
          end
        end
        hs_last = s_rvalid[gnt_q] & s_rready_c[gnt_q] & s_rlast[gnt_q];
        if (hs_last) begin
          state_d = ST_IDLE;
          rr_d    = rr_next(gnt_q);
          msel_d  = MS_NONE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_axi_r_router.sv
// Randomized bench for axi_r_router: queue-fed slave drivers, a per-cycle
// behavioural model of arbitration/steering, and directed literal scenarios.
module tb_axi_r_router;
  localparam int unsigned IDS = 8;
  localparam int unsigned IDB = 4;
  localparam int unsigned DW  = 32;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_r_if #(.ID_W(IDS), .DATA_W(DW)) s0_if ();
  axi_r_if #(.ID_W(IDS), .DATA_W(DW)) s1_if ();
  axi_r_if #(.ID_W(IDS), .DATA_W(DW)) sd_if ();
  axi_r_if #(.ID_W(IDB), .DATA_W(DW)) m0_if ();
  axi_r_if #(.ID_W(IDB), .DATA_W(DW)) m1_if ();

  axi_r_router #(.IDS_BITS(IDS), .ID_BITS(IDB), .DATA_BITS(DW)) dut (
    .ACLK  (clk),
    .ARESET(rst),
    .s0_if (s0_if),
    .s1_if (s1_if),
    .sd_if (sd_if),
    .m0_if (m0_if),
    .m1_if (m1_if)
  );

  logic [7:0]  s_rid  [3];
  logic [31:0] s_data [3];
  logic [1:0]  s_resp [3];
  logic [2:0]  s_last;
  logic [2:0]  s_vld;
  logic [1:0]  m_rdy;
  wire  [2:0]  s_rdy = {sd_if.rready, s1_if.rready, s0_if.rready};
  wire  [39:0] m_pk [2];

  assign s0_if.rid = s_rid[0];  assign s0_if.rdata = s_data[0];
  assign s0_if.rresp = s_resp[0]; assign s0_if.rlast = s_last[0]; assign s0_if.rvalid = s_vld[0];
  assign s1_if.rid = s_rid[1];  assign s1_if.rdata = s_data[1];
  assign s1_if.rresp = s_resp[1]; assign s1_if.rlast = s_last[1]; assign s1_if.rvalid = s_vld[1];
  assign sd_if.rid = s_rid[2];  assign sd_if.rdata = s_data[2];
  assign sd_if.rresp = s_resp[2]; assign sd_if.rlast = s_last[2]; assign sd_if.rvalid = s_vld[2];
  assign m0_if.rready = m_rdy[0];
  assign m1_if.rready = m_rdy[1];
  assign m_pk[0] = {m0_if.rvalid, m0_if.rid, m0_if.rdata, m0_if.rresp, m0_if.rlast};
  assign m_pk[1] = {m1_if.rvalid, m1_if.rid, m1_if.rdata, m1_if.rresp, m1_if.rlast};

  beat_t       sq [3][$];
  logic [39:0] mcap [2][$];
  int          order [$];
  int          checks = 0;
  int          errors = 0;

  // Model: is a burst in flight, who owns it, where it goes (-1 = drained), next priority.
  bit m_busy;
  int m_own, m_dst, m_ptr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_slaves();
    for (int i = 0; i < 3; i++) begin
      if (sq[i].size() > 0) begin
        s_vld[i] = 1'b1;        s_rid[i]  = sq[i][0].id;
        s_data[i] = sq[i][0].data; s_resp[i] = sq[i][0].resp; s_last[i] = sq[i][0].last;
      end else begin
        s_vld[i] = 1'b0; s_rid[i] = '0; s_data[i] = '0; s_resp[i] = '0; s_last[i] = 1'b0;
      end
    end
  endtask

  task automatic push_beat(input int s, input logic [7:0] id, input logic [31:0] d, input logic l);
    beat_t b;
    b.id = id; b.data = d; b.resp = d[1:0]; b.last = l;
    sq[s].push_back(b);
    drive_slaves();
  endtask

  task automatic push_burst(input int s, input int n, input logic [7:0] id, input logic [31:0] base);
    for (int b = 0; b < n; b++) push_beat(s, id, base + 32'(b), (b == n - 1));
  endtask

  function automatic int dest_of(input logic [7:0] id);
    if (id[7:4] == 4'd0) return 0;
    if (id[7:4] == 4'd1) return 1;
    return -1;
  endfunction

  // One clock: compare at negedge, advance model and slave queues after posedge.
  task automatic cycle();
    logic [39:0] exp_pk [2];
    logic [2:0]  exp_sr, hs;
    bit nb, rst_s;
    int no, nd, np, idx;
    @(negedge clk);
    exp_pk[0] = '0; exp_pk[1] = '0; exp_sr = '0;
    if (m_busy) begin
      if (m_dst >= 0) begin
        if (s_vld[m_own])
          exp_pk[m_dst] = {1'b1, s_rid[m_own][3:0], s_data[m_own], s_resp[m_own], s_last[m_own]};
        exp_sr[m_own] = m_rdy[m_dst];
      end else begin
        exp_sr[m_own] = 1'b1;
      end
    end
    chk("m0_out", 64'(m_pk[0]), 64'(exp_pk[0]));
    chk("m1_out", 64'(m_pk[1]), 64'(exp_pk[1]));
    chk("s_rready", 64'(s_rdy), 64'(exp_sr));
    hs = s_vld & s_rdy;
    for (int m = 0; m < 2; m++) if (m_pk[m][39] && m_rdy[m]) mcap[m].push_back(m_pk[m]);
    for (int i = 0; i < 3; i++) if (hs[i] && s_last[i]) order.push_back(i);
    nb = m_busy; no = m_own; nd = m_dst; np = m_ptr;
    if (!m_busy) begin
      for (int k = 0; k < 3; k++) begin
        idx = (m_ptr + k) % 3;
        if (!nb && s_vld[idx]) begin nb = 1'b1; no = idx; nd = dest_of(s_rid[idx]); end
      end
    end else if (s_vld[m_own] && exp_sr[m_own] && s_last[m_own]) begin
      nb = 1'b0; np = (m_own + 1) % 3;
    end
    rst_s = rst;
    @(posedge clk);
    if (rst_s) begin m_busy = 1'b0; m_ptr = 0; end
    else begin m_busy = nb; m_own = no; m_dst = nd; m_ptr = np; end
    #1;
    for (int i = 0; i < 3; i++) if (hs[i]) void'(sq[i].pop_front());
    drive_slaves();
  endtask

  function automatic bit all_empty();
    return (sq[0].size() == 0) && (sq[1].size() == 0) && (sq[2].size() == 0);
  endfunction

  task automatic run_drain(input int max, output int n);
    n = 0;
    while (!all_empty() && n < max) begin cycle(); n++; end
    if (!all_empty()) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d cycles required=<%0d", n, max);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) sq[i].delete();
    drive_slaves();
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
  endtask

  task automatic clear_logs();
    mcap[0].delete(); mcap[1].delete(); order.delete();
  endtask

  initial begin
    int n;
    int pat [5];
    bit rep;
    rst = 1'b1; m_rdy = 2'b00;
    m_busy = 1'b0; m_own = 0; m_dst = -1; m_ptr = 0;
    drive_slaves();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    #1;
    chk("reset_s_rready", 64'(s_rdy), 64'd0);
    chk("reset_m_rvalid", 64'({m_pk[1][39], m_pk[0][39]}), 64'd0);

    // Single 4-beat burst S0 -> M0
    clear_logs(); m_rdy = 2'b11;
    push_burst(0, 4, 8'h03, 32'hA0);
    run_drain(20, n);
    chk("t1_cycles", 64'(n), 64'd5);
    cycle();
    chk("t1_m0_beats", 64'(mcap[0].size()), 64'd4);
    chk("t1_m1_beats", 64'(mcap[1].size()), 64'd0);
    for (int b = 0; b < 4 && b < mcap[0].size(); b++) begin
      chk("t1_rid", 64'(mcap[0][b][38:35]), 64'h3);
      chk("t1_data", 64'(mcap[0][b][34:3]), 64'(32'hA0 + 32'(b)));
    end

    // S1 -> M1 with toggling RREADY
    do_reset(); clear_logs(); m_rdy = 2'b01;
    push_burst(1, 2, 8'h15, 32'hB0);
    pat = '{0, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) begin m_rdy[1] = pat[i][0]; cycle(); end
    chk("t2_m1_beats", 64'(mcap[1].size()), 64'd2);
    chk("t2_s1_left", 64'(sq[1].size()), 64'd0);
    for (int b = 0; b < 2 && b < mcap[1].size(); b++) begin
      chk("t2_rid", 64'(mcap[1][b][38:35]), 64'h5);
      chk("t2_data", 64'(mcap[1][b][34:3]), 64'(32'hB0 + 32'(b)));
    end
    m_rdy = 2'b11; cycle();

    // Round-robin across all three, then with S0 re-requesting
    do_reset(); clear_logs();
    push_burst(0, 1, 8'h00, 32'h10); push_burst(1, 1, 8'h01, 32'h11); push_burst(2, 1, 8'h02, 32'h12);
    run_drain(30, n); cycle();
    chk("t3_count", 64'(order.size()), 64'd3);
    for (int i = 0; i < 3 && i < order.size(); i++) chk("t3_order", 64'(order[i]), 64'(i));
    clear_logs(); rep = 1'b0; n = 0;
    push_burst(0, 1, 8'h00, 32'h20); push_burst(1, 1, 8'h01, 32'h21); push_burst(2, 1, 8'h02, 32'h22);
    while (order.size() < 4 && n < 40) begin
      if (order.size() >= 1 && !rep) begin push_burst(0, 1, 8'h00, 32'h23); rep = 1'b1; end
      cycle(); n++;
    end
    chk("t3b_count", 64'(order.size()), 64'd4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk("t3b_order", 64'(order[i]), 64'(i % 3));
    cycle();

    // Illegal master index drained from SD
    clear_logs();
    push_burst(2, 3, 8'h27, 32'hC0);
    run_drain(20, n);
    chk("t4_cycles", 64'(n), 64'd4);
    cycle();
    chk("t4_order", 64'(order.size() == 1 ? order[0] : -1), 64'd2);
    chk("t4_m_beats", 64'(mcap[0].size() + mcap[1].size()), 64'd0);

    // Grant lock against a late requester and a changing RID
    do_reset(); clear_logs();
    push_beat(0, 8'h03, 32'hD0, 1'b0); push_beat(0, 8'h1F, 32'hD1, 1'b0); push_beat(0, 8'h03, 32'hD2, 1'b1);
    cycle();
    push_burst(1, 1, 8'h12, 32'hE0);
    run_drain(20, n); cycle();
    chk("t5_m0_beats", 64'(mcap[0].size()), 64'd3);
    chk("t5_m1_beats", 64'(mcap[1].size()), 64'd1);
    if (mcap[0].size() == 3) chk("t5_rid_beat2", 64'(mcap[0][1][38:35]), 64'hF);
    chk("t5_first", 64'(order.size() == 2 ? order[0] : -1), 64'd0);

    // Reset during beat 2 of an S1 burst
    do_reset(); clear_logs();
    push_burst(1, 4, 8'h01, 32'hF0);
    cycle(); cycle();
    rst = 1'b1;
    push_burst(0, 1, 8'h00, 32'hF8);
    cycle();
    rst = 1'b0;
    #1;
    chk("t6_s_rready", 64'(s_rdy), 64'd0);
    chk("t6_m_rvalid", 64'({m_pk[1][39], m_pk[0][39]}), 64'd0);
    order.delete();
    run_drain(30, n); cycle();
    chk("t6_first", 64'(order.size() > 0 ? order[0] : -1), 64'd0);

    // Randomized traffic with random backpressure and occasional resets
    do_reset(); clear_logs();
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < 3; s++) begin
        if (sq[s].size() < 6 && $urandom_range(5) == 0) begin
          logic [3:0] up;
          case ($urandom_range(7))
            0, 1, 2: up = 4'd0;
            3, 4, 5: up = 4'd1;
            6:       up = 4'd2;
            default: up = 4'hF;
          endcase
          push_burst(s, int'($urandom_range(4, 1)), {up, 4'($urandom)}, $urandom);
        end
      end
      m_rdy = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
      rst = ($urandom_range(499) == 0);
      cycle();
    end
    rst = 1'b0; m_rdy = 2'b11;
    run_drain(300, n);
    cycle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule

// File: doc/axi_r_router.md
Name: axi_r_router

Overview:
- Return-path counterpart of the AXI address decoder. Routes read-data (R) bursts from three slave ports (S0, S1, SDEFAULT) back to one of two master ports (M0, M1).
- Arbitrates between slaves with simultaneous RVALID using round-robin and holds the grant for a whole burst until the RLAST handshake.
- Steers each burst to a master using the master index carried in the upper bits of the slave-side RID, and strips those bits on the way out.
- Sits in the AXI interconnect next to the AR/AW decoders.

Parameters:
- IDS_BITS, 8, slave-side ID width; upper (IDS_BITS-ID_BITS) bits are the master index.
- ID_BITS, 4, master-side ID width.
- DATA_BITS, 32, RDATA width.

Ports:
- ACLK  in  1  clock, all state on rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- RID_Sx  in  IDS_BITS  slave read ID, x in {S0,S1,SD}.
- RDATA_Sx  in  DATA_BITS  slave read data.
- RRESP_Sx  in  2  slave read response.
- RLAST_Sx  in  1  slave last beat.
- RVALID_Sx  in  1  slave valid.
- RREADY_Sx  out  1  ready to slave x.
- RID_My  out  ID_BITS  master read ID, y in {M0,M1}.
- RDATA_My  out  DATA_BITS  master read data.
- RRESP_My  out  2  master read response.
- RLAST_My  out  1  master last beat.
- RVALID_My  out  1  master valid.
- RREADY_My  in  1  master ready.

Behaviour:
- State: FSM {IDLE, BUSY}; grant register gnt in {S0,S1,SD}; master-select register msel in {M0,M1,NONE}; round-robin pointer rr in {S0,S1,SD}.
- Reset: ARESET=1 at a rising edge sets state=IDLE, gnt=S0, msel=NONE, rr=S0. Reset mid-burst abandons the burst immediately; the slave is not drained.
- Outputs in IDLE: all RVALID_My=0 and all RREADY_Sx=0. Data/ID/RESP/LAST outputs are 0 whenever the corresponding RVALID_My=0.
- Arbitration in IDLE: if any RVALID_Sx=1, choose the first requesting slave in order rr, rr+1, rr+2 (mod 3, order S0->S1->SD->S0).
  - Next cycle: state=BUSY, gnt=chosen slave.
  - msel decoded from chosen RID_Sx[IDS_BITS-1:ID_BITS]: 0->M0, 1->M1, any other value->NONE.
  - Arbitration latency is 1 cycle; no beat transfers in the IDLE cycle.
- BUSY with msel=My:
  - RVALID_My=RVALID_gnt.
  - RID_My=RID_gnt[ID_BITS-1:0]; RDATA_My, RRESP_My, RLAST_My copied from gnt.
  - RREADY_gnt=RREADY_My.
  - Other master RVALID=0; other slaves RREADY=0.
  - The path is combinational; there is no data buffering.
- BUSY with msel=NONE (illegal master index): RREADY_gnt=1 so the burst is drained; all RVALID_My=0.
- Burst end: a handshake (RVALID_gnt & RREADY_gnt) with RLAST_gnt=1 sets next state=IDLE, rr=gnt+1 (mod 3), msel=NONE.
  - Non-last handshakes stay in BUSY.
  - gnt and msel never change inside a burst, even if RID changes.
- Backpressure: RREADY_My=0 holds the beat. The slave must keep its outputs stable, and the router keeps presenting them. There is no timeout.
- Losing requesters: slaves that lose arbitration keep RVALID high and are served in later bursts. Round-robin guarantees any persistently requesting slave is served within 2 other bursts.
- Next burst: after returning to IDLE, the next burst needs 1 IDLE cycle. Back-to-back bursts therefore have a 1-cycle bubble.
- Simultaneous ARESET and RLAST handshake: reset wins.

Test Plan:
- Single burst to M0: S0 presents RID=8'h03, 4 beats RDATA 32'hA0..A3, RLAST on beat 4, RREADY_M0=1 -> M0 sees RID=4'h3 and 4 consecutive beats starting 1 cycle after RVALID_S0 rises. Returns to IDLE after beat 4; RVALID_M1 stays 0 throughout.
- Routing to M1 with backpressure: S1 with RID=8'h15, 2 beats; RREADY_M1 toggles 0,1,0,1 -> data held stable while ready=0, exactly 2 handshakes, RID_M1=4'h5, RREADY_S0 and RREADY_SD=0 throughout.
- Round-robin: S0, S1, SD all assert RVALID at once, 1 beat each, rr=S0 after reset -> service order S0, S1, SD. Rerun with S0 re-requesting immediately -> order S0, S1, SD, S0.
- Illegal index: SD presents RID=8'h27, 3 beats -> RREADY_SD=1 in all 3 BUSY cycles, both RVALID_My=0, FSM back to IDLE after RLAST.
- Grant lock: during an S0 burst to M0, S1 asserts RVALID and S0's RID changes to 8'h1F on beat 2 -> M0 still receives all S0 beats, RREADY_S1=0, S1 granted only after S0's RLAST.
- Reset mid-burst: assert ARESET on beat 2 of a 4-beat S1 burst -> next cycle all RVALID_My=0 and RREADY_Sx=0, rr=S0. After release, the first requester granted is S0 if both S0 and S1 are valid.
